// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if : MEM/WB inputs, ID read ports and forwarding/retire outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface wb_regfile_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             valid_i;
  logic [1:0]       wb_sel_i;
  logic             rd_wren_i;
  logic [4:0]       rd_addr_i;
  logic [XLEN-1:0]  alu_data_i;
  logic [XLEN-1:0]  ld_data_i;
  logic [XLEN-1:0]  pc_i;
  logic [4:0]       rs1_addr_i;
  logic [4:0]       rs2_addr_i;
  logic [XLEN-1:0]  rs1_data_o;
  logic [XLEN-1:0]  rs2_data_o;
  logic             wb_we_o;
  logic [4:0]       wb_addr_o;
  logic [XLEN-1:0]  wb_data_o;
  logic [CNT_W-1:0] retire_o;

  modport slave (
    input  valid_i, wb_sel_i, rd_wren_i, rd_addr_i, alu_data_i, ld_data_i, pc_i,
    input  rs1_addr_i, rs2_addr_i,
    output rs1_data_o, rs2_data_o, wb_we_o, wb_addr_o, wb_data_o, retire_o
  );

  modport master (
    output valid_i, wb_sel_i, rd_wren_i, rd_addr_i, alu_data_i, ld_data_i, pc_i,
    output rs1_addr_i, rs2_addr_i,
    input  rs1_data_o, rs2_data_o, wb_we_o, wb_addr_o, wb_data_o, retire_o
  );
endinterface

`default_nettype wire

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile : RV32I writeback mux, x1..x31 register file with write bypass,
//              and retired-instruction counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_regfile #(
  parameter int XLEN   = 32,
  parameter int PC_INC = 4,
  parameter int CNT_W  = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  wb_regfile_if.slave  bus
);

  logic [XLEN-1:0]  regs_q [32];
  logic [XLEN-1:0]  regs_d [32];
  logic [CNT_W-1:0] retire_q;
  logic [CNT_W-1:0] retire_d;

  logic [XLEN-1:0]  wb_data;
  logic             wb_we;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;

  // Encoding 11 is folded onto the ALU result so no input pattern yields X.
  always_comb begin
    wb_data = bus.alu_data_i;
    case (bus.wb_sel_i)
      2'b01:   wb_data = bus.ld_data_i;
      2'b10:   wb_data = bus.pc_i + XLEN'(PC_INC);
      default: wb_data = bus.alu_data_i;
    endcase
  end

  assign wb_we = bus.valid_i & bus.rd_wren_i & (bus.rd_addr_i != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wb_we) begin
      regs_d[bus.rd_addr_i] = wb_data;
    end
    // Entry 0 is a constant zero; the flop is kept only so indexing stays uniform.
    regs_d[0] = '0;
    retire_d  = retire_q + CNT_W'(bus.valid_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      retire_q <= '0;
    end else begin
      regs_q   <= regs_d;
      retire_q <= retire_d;
    end
  end

  // Write-before-read: an instruction in ID sees the value being committed this cycle.
  always_comb begin
    rs1_data = regs_q[bus.rs1_addr_i];
    if (bus.rs1_addr_i == 5'd0) begin
      rs1_data = '0;
    end else if (wb_we && (bus.rs1_addr_i == bus.rd_addr_i)) begin
      rs1_data = wb_data;
    end
  end

  always_comb begin
    rs2_data = regs_q[bus.rs2_addr_i];
    if (bus.rs2_addr_i == 5'd0) begin
      rs2_data = '0;
    end else if (wb_we && (bus.rs2_addr_i == bus.rd_addr_i)) begin
      rs2_data = wb_data;
    end
  end

  assign bus.rs1_data_o = rs1_data;
  assign bus.rs2_data_o = rs2_data;
  assign bus.wb_we_o    = wb_we;
  assign bus.wb_addr_o  = bus.rd_addr_i;
  assign bus.wb_data_o  = wb_data;
  assign bus.retire_o   = retire_q;

endmodule

`default_nettype wire
